// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered ALU-control decoder with a DEPTH-entry result FIFO,
// flush and a saturating illegal-op counter.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of queued entries (counter kept)
//   in_valid/in_ready   input handshake; in_ready = !full
//   in_instr, in_aluop  instruction word and ALUop from main decode
//   out_valid/out_ready output handshake on the FIFO head
//   out_ctrl            4-bit ALU control of head
//   out_illegal         head is an illegal ALU op
//   out_instr           instruction of head
//   illegal_cnt         saturating count of accepted illegal ops
module alu_decode_stage #(
   parameter int W       = 32,
   parameter int DEPTH   = 2,
   parameter int EXT_OPS = 1,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_instr,
   input  logic [1:0]       in_aluop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_ctrl,
   output logic             out_illegal,
   output logic [W-1:0]     out_instr,
   output logic [CNT_W-1:0] illegal_cnt
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [3:0]    ctrl_mem  [DEPTH];
   logic          ill_mem   [DEPTH];
   logic [W-1:0]  instr_mem [DEPTH];
   logic [3:0]    hold_ctrl;
   logic          hold_ill;
   logic [W-1:0]  hold_instr;
   logic [2:0]    f3;
   logic          f7_5, op5, ext_op, push, pop;
   logic [3:0]    dec_ctrl;
   logic          dec_ill;

   assign f3     = in_instr[W-18:W-20];
   assign f7_5   = in_instr[W-2];
   // opcode bit 5 separates R-type (sub possible) from I-type (addi never subtracts)
   assign op5    = in_instr[W-27];
   assign ext_op = (f3 == 3'b001) || (f3 == 3'b011) || (f3 == 3'b100) || (f3 == 3'b101);

   always_comb begin
      dec_ctrl = 4'b0000;
      dec_ill  = 1'b0;
      case (in_aluop)
         2'b01: dec_ctrl = 4'b0001;
         2'b11: dec_ill  = 1'b1;
         2'b10: begin
            case (f3)
               3'b000: dec_ctrl = (op5 && f7_5) ? 4'b0001 : 4'b0000;
               3'b001: dec_ctrl = 4'b0111;
               3'b010: dec_ctrl = 4'b0101;
               3'b011: dec_ctrl = 4'b0110;
               3'b100: dec_ctrl = 4'b0100;
               3'b101: dec_ctrl = f7_5 ? 4'b1001 : 4'b1000;
               3'b110: dec_ctrl = 4'b0011;
               default: dec_ctrl = 4'b0010;
            endcase
            if (EXT_OPS == 0 && ext_op) begin
               dec_ctrl = 4'b0000;
               dec_ill  = 1'b1;
            end
         end
         default: dec_ctrl = 4'b0000;
      endcase
   end

   assign in_ready  = count != (AW+1)'(DEPTH);
   assign out_valid = count != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // when empty the outputs show the last head that was presented
   assign out_ctrl    = out_valid ? ctrl_mem[rd_ptr]  : hold_ctrl;
   assign out_illegal = out_valid ? ill_mem[rd_ptr]   : hold_ill;
   assign out_instr   = out_valid ? instr_mem[rd_ptr] : hold_instr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         hold_ctrl   <= '0;
         hold_ill    <= 1'b0;
         hold_instr  <= '0;
         illegal_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_mem[i]  <= '0;
            ill_mem[i]   <= 1'b0;
            instr_mem[i] <= '0;
         end
      end else begin
         if (out_valid) begin
            hold_ctrl  <= ctrl_mem[rd_ptr];
            hold_ill   <= ill_mem[rd_ptr];
            hold_instr <= instr_mem[rd_ptr];
         end
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               ctrl_mem[wr_ptr]  <= dec_ctrl;
               ill_mem[wr_ptr]   <= dec_ill;
               instr_mem[wr_ptr] <= in_instr;
               wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push && dec_ill && illegal_cnt != '1)
               illegal_cnt <= illegal_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: randomized and directed bench for alu_decode_stage; one
// instance with extended ops and an 8-bit counter, one with EXT_OPS=0 and CNT_W=2.
module tb_alu_decode_stage;
   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic [1:0]  in_aluop;
   logic        rdy0, vld0, ill0, rdy1, vld1, ill1;
   logic [3:0]  ctrl0, ctrl1;
   logic [31:0] ins0, ins1;
   logic [7:0]  cnt0;
   logic [1:0]  cnt1;

   typedef struct {logic [31:0] instr; logic [1:0] op;} ent_t;
   ent_t q[$];
   int   m_cnt0, m_cnt1, checks, errors;

   always #5 clk = ~clk;

   alu_decode_stage u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
      .in_instr(in_instr), .in_aluop(in_aluop), .out_valid(vld0), .out_ready(out_ready),
      .out_ctrl(ctrl0), .out_illegal(ill0), .out_instr(ins0), .illegal_cnt(cnt0));

   alu_decode_stage #(.EXT_OPS(0), .CNT_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
      .in_instr(in_instr), .in_aluop(in_aluop), .out_valid(vld1), .out_ready(out_ready),
      .out_ctrl(ctrl1), .out_illegal(ill1), .out_instr(ins1), .illegal_cnt(cnt1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference decode: {illegal, ctrl} straight from the ALUop/funct3 table
   function automatic logic [4:0] dec(input logic [31:0] i, input logic [1:0] op, input bit ext);
      logic [2:0] f3;
      f3 = i[14:12];
      if (op == 2'b00) return 5'h00;
      if (op == 2'b01) return 5'h01;
      if (op == 2'b11) return 5'h10;
      if (!ext && (f3 == 1 || f3 == 3 || f3 == 4 || f3 == 5)) return 5'h10;
      case (f3)
         3'd0: return (i[5] && i[30]) ? 5'h01 : 5'h00;
         3'd1: return 5'h07;
         3'd2: return 5'h05;
         3'd3: return 5'h06;
         3'd4: return 5'h04;
         3'd5: return i[30] ? 5'h09 : 5'h08;
         3'd6: return 5'h03;
         default: return 5'h02;
      endcase
   endfunction

   task automatic check_all();
      logic [4:0] d0, d1;
      chk("valid0", vld0, q.size() != 0);
      chk("ready0", rdy0, q.size() < 2);
      chk("cnt0", cnt0, m_cnt0);
      chk("valid1", vld1, q.size() != 0);
      chk("ready1", rdy1, q.size() < 2);
      chk("cnt1", cnt1, m_cnt1);
      if (q.size() != 0) begin
         d0 = dec(q[0].instr, q[0].op, 1);
         d1 = dec(q[0].instr, q[0].op, 0);
         chk("ctrl0", ctrl0, d0[3:0]);
         chk("ill0", ill0, d0[4]);
         chk("instr0", ins0, q[0].instr);
         chk("ctrl1", ctrl1, d1[3:0]);
         chk("ill1", ill1, d1[4]);
         chk("instr1", ins1, q[0].instr);
      end
   endtask

   task automatic chk_rst();
      chk("rst_valid0", vld0, 0);
      chk("rst_ready0", rdy0, 1);
      chk("rst_ctrl0", ctrl0, 0);
      chk("rst_ill0", ill0, 0);
      chk("rst_instr0", ins0, 0);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_valid1", vld1, 0);
      chk("rst_ready1", rdy1, 1);
      chk("rst_cnt1", cnt1, 0);
   endtask

   // one clock: check state at negedge, drive inputs, advance model on the edge
   task automatic cyc(input logic v, input logic [31:0] ins, input logic [1:0] op,
                      input logic rdy, input logic fl);
      bit   do_push, do_pop;
      ent_t e;
      logic [4:0] d0, d1;
      check_all();
      in_valid = v; in_instr = ins; in_aluop = op; out_ready = rdy; flush = fl;
      do_push = v && q.size() < 2;
      do_pop  = rdy && q.size() != 0;
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.instr = ins; e.op = op;
            q.push_back(e);
            d0 = dec(ins, op, 1);
            d1 = dec(ins, op, 0);
            if (d0[4] && m_cnt0 < 255) m_cnt0++;
            if (d1[4] && m_cnt1 < 3) m_cnt1++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      checks = 0; errors = 0; m_cnt0 = 0; m_cnt1 = 0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_aluop = '0;
      #1 chk_rst();
      @(negedge clk) rst_n = 1'b1;
      // sub then addi with f7_5 set; fill to full, third push ignored, then drain
      cyc(1, 32'h4000_0033, 2'b10, 0, 0);
      cyc(1, 32'h4000_0013, 2'b10, 0, 0);
      cyc(1, 32'h0000_7033, 2'b10, 0, 0);
      cyc(0, 32'h0, 2'b00, 1, 0);
      cyc(0, 32'h0, 2'b00, 1, 0);
      // extended ops streamed
      cyc(1, 32'h4000_5013, 2'b10, 1, 0);
      cyc(1, 32'h0000_4033, 2'b10, 1, 0);
      cyc(1, 32'h0000_3033, 2'b10, 1, 0);
      cyc(0, 32'h0, 2'b00, 1, 0);
      // continuous push/pop with ALUop cycling
      for (int i = 0; i < 10; i++)
         cyc(1, $urandom, 2'(i), 1, 0);
      cyc(0, 32'h0, 2'b00, 1, 0);
      // saturate the 2-bit counter
      for (int i = 0; i < 5; i++)
         cyc(1, $urandom, 2'b11, 1, 0);
      cyc(0, 32'h0, 2'b00, 1, 0);
      // flush with two queued and a same-cycle illegal push
      cyc(1, 32'h0000_0033, 2'b10, 0, 0);
      cyc(1, 32'h4000_0033, 2'b10, 0, 0);
      cyc(0, 32'h0, 2'b00, 0, 0);
      cyc(1, 32'h1234_5678, 2'b11, 1, 1);
      cyc(1, 32'h0000_6033, 2'b10, 0, 0);
      // asynchronous reset mid-stream with two queued
      cyc(1, 32'h0000_1033, 2'b10, 0, 0);
      cyc(0, 32'h0, 2'b00, 0, 0);
      #2 rst_n = 1'b0;
      #1 chk_rst();
      q.delete(); m_cnt0 = 0; m_cnt1 = 0;
      @(negedge clk) rst_n = 1'b1;
      cyc(0, 32'h0, 2'b00, 0, 0);
      // random traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(3) != 0, $urandom, 2'($urandom), $urandom_range(2) != 0,
             $urandom_range(24) == 0);
      check_all();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
